// File: rtl/glitch_sweep_tx.sv
// glitch_sweep_tx -- power-cut glitch sweeper with a UART-framed payload.
//
// A start request runs SWEEP_COUNT attempts. Each attempt waits an offset,
// drops target power for PWR_OFF_CYCLES, sends PAYLOAD (MSB byte first, each
// byte LSB-first in a start/data/stop frame of CLK_DIV clocks per bit), then
// idles GAP_CYCLES. The offset grows by OFFSET_STEP per attempt.
//
// Optional build macro: GLITCH_TX_PARITY_EN adds an even-parity bit between
// data bit 7 and the stop bit (11-bit frames). Undefined: 8N1 frames.
//
// Ports:
//   clk_in   in   system clock
//   rst      in   synchronous active-high reset
//   start    in   run request, honoured only in IDLE or DONE
//   abort    in   return to IDLE from any busy state (wins over start)
//   busy     out  high in WAIT, PWR_OFF, SEND, GAP
//   done     out  high in DONE
//   attempt  out  index of the current or last attempt
//   bang_tx  out  UART line to the target, idles high
//   power_tx out  target power enable, 1 = powered
//   led      out  active-low status: IDLE all off, busy ~attempt, DONE all on
// All outputs are registered.
module glitch_sweep_tx #(
  parameter int                         CLK_DIV        = 4,
  parameter int                         PAYLOAD_BYTES  = 2,
  parameter logic [8*PAYLOAD_BYTES-1:0] PAYLOAD        = 16'hFAEB,
  parameter int                         OFFSET_START   = 10,
  parameter int                         OFFSET_STEP    = 2,
  parameter int                         SWEEP_COUNT    = 1,
  parameter int                         PWR_OFF_CYCLES = 5,
  parameter int                         GAP_CYCLES     = 8,
  parameter int                         CNT_W          = 24
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic [5:0] attempt,
  output logic       bang_tx,
  output logic       power_tx,
  output logic [5:0] led
);

`ifdef GLITCH_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int BIT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT, ST_PWR_OFF, ST_SEND, ST_GAP, ST_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;      // cycles left in WAIT/PWR_OFF/GAP
  logic [CNT_W-1:0]        off_q, off_d;      // offset of the current attempt
  logic [FRAME_BITS-1:0]   frame_q, frame_d;  // frame shifter, bit 0 on the line
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [BIDX_W-1:0]       byte_q, byte_d;
  logic [5:0]              attempt_q, attempt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    bang_q, bang_d;
  logic                    power_q, power_d;
  logic [5:0]              led_q, led_d;
  logic                    launch;            // begin an attempt with offset off_d

  function automatic logic [7:0] payload_byte(input logic [BIDX_W-1:0] idx);
    logic [8*PAYLOAD_BYTES-1:0] p;
    p = PAYLOAD >> (8 * (PAYLOAD_BYTES - 1 - int'(idx)));
    return p[7:0];
  endfunction

  // Frame laid out LSB-first so shifting right walks start, data, (parity), stop.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] b);
`ifdef GLITCH_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    off_d     = off_q;
    frame_d   = frame_q;
    bit_d     = bit_q;
    div_d     = div_q;
    byte_d    = byte_q;
    attempt_d = attempt_q;
    launch    = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && !abort) begin
          attempt_d = '0;
          off_d     = CNT_W'(OFFSET_START);
          launch    = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_PWR_OFF;
          cnt_d   = CNT_W'(PWR_OFF_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PWR_OFF: begin
        if (cnt_q == '0) begin
          state_d = ST_SEND;
          byte_d  = '0;
          bit_d   = '0;
          div_d   = DIV_W'(CLK_DIV - 1);
          frame_d = make_frame(payload_byte('0));
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SEND: begin
        if (div_q != '0) begin
          div_d = div_q - 1'b1;
        end else begin
          div_d = DIV_W'(CLK_DIV - 1);
          if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
            if (byte_q == BIDX_W'(PAYLOAD_BYTES - 1)) begin
              state_d = ST_GAP;
              cnt_d   = CNT_W'(GAP_CYCLES - 1);
            end else begin
              // Next byte follows the stop bit with no idle time.
              byte_d  = byte_q + 1'b1;
              bit_d   = '0;
              frame_d = make_frame(payload_byte(byte_d));
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            frame_d = {1'b1, frame_q[FRAME_BITS-1:1]};
          end
        end
      end
      ST_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (attempt_q == 6'(SWEEP_COUNT - 1)) begin
          state_d = ST_DONE;
        end else begin
          attempt_d = attempt_q + 1'b1;
          off_d     = off_q + CNT_W'(OFFSET_STEP);  // wraps modulo 2^CNT_W
          launch    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A zero offset skips WAIT so the power cut starts on the attempt's first cycle.
    if (launch) begin
      if (off_d == '0) begin
        state_d = ST_PWR_OFF;
        cnt_d   = CNT_W'(PWR_OFF_CYCLES - 1);
      end else begin
        state_d = ST_WAIT;
        cnt_d   = off_d - 1'b1;
      end
    end

    if (abort && busy_q) begin
      state_d   = ST_IDLE;
      attempt_d = attempt_q;
    end

    // Outputs are decoded from the next state so their registers line up with it.
    busy_d  = (state_d == ST_WAIT) || (state_d == ST_PWR_OFF) ||
              (state_d == ST_SEND) || (state_d == ST_GAP);
    done_d  = (state_d == ST_DONE);
    power_d = (state_d != ST_PWR_OFF);
    bang_d  = (state_d == ST_SEND) ? frame_d[0] : 1'b1;
    if (state_d == ST_DONE)  led_d = 6'b000000;
    else if (busy_d)         led_d = ~attempt_d;
    else                     led_d = 6'b111111;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      off_q     <= '0;
      frame_q   <= '1;
      bit_q     <= '0;
      div_q     <= '0;
      byte_q    <= '0;
      attempt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bang_q    <= 1'b1;
      power_q   <= 1'b1;
      led_q     <= 6'b111111;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      off_q     <= off_d;
      frame_q   <= frame_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      byte_q    <= byte_d;
      attempt_q <= attempt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bang_q    <= bang_d;
      power_q   <= power_d;
      led_q     <= led_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign attempt  = attempt_q;
  assign bang_tx  = bang_q;
  assign power_tx = power_q;
  assign led      = led_q;

endmodule

// File: tb/tb_glitch_sweep_tx.sv
// Directed bench for glitch_sweep_tx: a default instance and a 3-attempt
// sweep instance share clock and inputs. Cycle 0 is the cycle in which start
// is driven; outputs are sampled 1 time unit after each rising edge.
module tb_glitch_sweep_tx;

  logic clk_in = 1'b0;
  logic rst, start, abort;
  logic       busy, done, bang_tx, power_tx;
  logic [5:0] attempt, led;
  logic       busy3, done3, bang3, power3;
  logic [5:0] attempt3, led3;

  int total = 0;
  int bad   = 0;

`ifdef GLITCH_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FLEN  = FB * 4;
  localparam int SEND0 = 16;
  localparam int GAP0  = SEND0 + 2 * FLEN;
  localparam int DONE0 = GAP0 + 8;
  // Start cycles of each attempt for the 3-attempt instance (offsets 10, 12, 14).
  localparam int S1  = 1 + 10 + 5 + 2 * FLEN + 8;
  localparam int S2  = S1 + 12 + 5 + 2 * FLEN + 8;
  localparam int DN3 = S2 + 14 + 5 + 2 * FLEN + 8;

  always #5 clk_in = ~clk_in;

  glitch_sweep_tx dut (
    .clk_in(clk_in), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .attempt(attempt),
    .bang_tx(bang_tx), .power_tx(power_tx), .led(led)
  );

  glitch_sweep_tx #(.SWEEP_COUNT(3)) dut3 (
    .clk_in(clk_in), .rst(rst), .start(start), .abort(abort),
    .busy(busy3), .done(done3), .attempt(attempt3),
    .bang_tx(bang3), .power_tx(power3), .led(led3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Expected line level for a default run whose start was sampled at cycle 0.
  function automatic logic exp_bang(input int c);
    int rel, b;
    logic [7:0] byt;
    if (c < SEND0 || c >= GAP0) return 1'b1;
    rel = c - SEND0;
    byt = (rel / FLEN == 0) ? 8'hFA : 8'hEB;
    b   = (rel % FLEN) / 4;
    if (b == 0) return 1'b0;
    if (b <= 8) return byt[b-1];
    if (FB == 11 && b == 9) return ^byt;
    return 1'b1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    step();
    check("reset_bang", bang_tx, 1);
    check("reset_power", power_tx, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_attempt", attempt, 0);
    check("reset_led", led, 6'h3F);
    do_reset();

    // Run 1: full default trace, start re-pulsed mid-SEND, plus the sweep instance.
    start = 1'b1;
    for (int c = 1; c <= DN3 + 2; c++) begin
      step();
      start = (c == 30);
      if (c <= DONE0 + 4) begin
        check("trace_bang", bang_tx, exp_bang(c));
        check("trace_power", power_tx, (c >= 11 && c <= 15) ? 0 : 1);
        check("trace_busy", busy, (c < DONE0) ? 1 : 0);
        check("trace_done", done, (c >= DONE0) ? 1 : 0);
      end
      if (c == 5)     check("busy_led", led, 6'h3F);
      if (c == DONE0) check("done_led", led, 6'h00);
      if (c == DONE0) check("done_attempt", attempt, 0);
      if (c == 11)    check("sw_pwr0", power3, 0);
      if (c == S1) begin
        check("sw_att1", attempt3, 1);
        check("sw_led1", led3, 6'h3E);
        check("sw_busy1", busy3, 1);
      end
      if (c == S1 + 11) check("sw_pwr1_on", power3, 1);
      if (c == S1 + 12) check("sw_pwr1_off", power3, 0);
      if (c == S2) begin
        check("sw_att2", attempt3, 2);
        check("sw_led2", led3, 6'h3D);
      end
      if (c == S2 + 13) check("sw_pwr2_on", power3, 1);
      if (c == S2 + 14) check("sw_pwr2_off", power3, 0);
      if (c == DN3 - 1) check("sw_busy_last", busy3, 1);
      if (c == DN3) begin
        check("sw_done", done3, 1);
        check("sw_busy_end", busy3, 0);
        check("sw_att_end", attempt3, 2);
        check("sw_led_end", led3, 6'h00);
      end
    end
    // Restart from DONE begins again at attempt 0.
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_att", attempt3, 0);
    check("restart_busy", busy3, 1);
    check("restart_done", done3, 0);
    check("restart_led", led3, 6'h3F);

    // Run 2: abort during the third bit of byte 0 (cycles 24-27).
    do_reset();
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      start = 1'b0;
      abort = (c == 25);
      if (c == 25) check("pre_abort_busy", busy, 1);
      if (c == 22) check("pre_abort_bit1", bang_tx, 0);
      if (c == 26) begin
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_bang", bang_tx, 1);
        check("abort_power", power_tx, 1);
        check("abort_led", led, 6'h3F);
      end
      if (c == 40) check("abort_stays_idle", busy, 0);
    end

    // Run 3: abort and start together during the power cut; abort wins.
    abort = 1'b0;
    do_reset();
    start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      step();
      start = (c == 12);
      abort = (c == 12);
    end
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", busy, 0);
    check("abort_start_power", power_tx, 1);

    // Run 4: rst asserted at cycle 13, in the middle of the power cut.
    do_reset();
    start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step();
      start = 1'b0;
      rst   = (c == 13);
      if (c == 12) check("pre_rst_power", power_tx, 0);
      if (c == 14) begin
        check("rst_power", power_tx, 1);
        check("rst_bang", bang_tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_attempt", attempt, 0);
        check("rst_led", led, 6'h3F);
      end
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
